// File: rtl/soc_master_wb_8_pkg.sv
// Shared constants, state encoding and header-byte mux for the soc_master_wb_8 bridge.
package soc_master_wb_8_pkg;

    localparam logic [3:0] CMD_READ   = 4'hA;
    localparam logic [3:0] CMD_WRITE  = 4'hB;
    localparam logic [7:0] FLAG_START = 8'h01;
    localparam logic [7:0] BYTE_TERM  = 8'h00;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StSendHdr   = 3'd1,
        StSendWdata = 3'd2,
        StWaitStart = 3'd3,
        StWaitData  = 3'd4,
        StSendTerm  = 3'd5,
        StDrain     = 3'd6,
        StAck       = 3'd7
    } state_e;

    // Header byte idx of a command frame: command nibble + adr[35:32], then adr[31:0] MSB first.
    function automatic logic [7:0] hdr_byte(input logic [35:0] adr, input logic we,
                                            input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {(we ? CMD_WRITE : CMD_READ), adr[35:32]};
            3'd1:    b = adr[31:24];
            3'd2:    b = adr[23:16];
            3'd3:    b = adr[15:8];
            default: b = adr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/soc_master_wb_8.sv
// Wishbone slave to byte-stream bridge: each access becomes one command frame toward an
// 8-bit SoC responder; read replies are parsed and the data byte returned on Wishbone.
module soc_master_wb_8
    import soc_master_wb_8_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    output logic [7:0]  wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [7:0]  output_axis_tdata,
    output logic        output_axis_tvalid,
    input  logic        output_axis_tready,
    output logic        output_axis_tlast,
    input  logic [7:0]  input_axis_tdata,
    input  logic        input_axis_tvalid,
    output logic        input_axis_tready,
    input  logic        input_axis_tlast,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [35:0] adr_q, adr_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  rdat_q, rdat_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        last_q, last_d;   // error came from an early tlast: responder frame already closed
    logic [15:0] tmo_q, tmo_d;

    logic [7:0]  tdata_d, dat_o_d;
    logic        tvalid_d, tlast_d, itready_d, busy_d, ack_d, werr_d;
    logic        out_hs, in_hs, tmo_hit;

    assign out_hs  = output_axis_tvalid & output_axis_tready;
    assign in_hs   = input_axis_tready & input_axis_tvalid;
    assign tmo_hit = (tmo_q == TIMEOUT - 16'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        we_d    = we_q;
        err_d   = err_q;
        last_d  = last_q;
        tmo_d   = tmo_q;

        case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
                    adr_d   = wb_adr_i;
                    wdat_d  = wb_dat_i;
                    we_d    = wb_we_i;
                    rdat_d  = 8'h00;
                    cnt_d   = 3'd0;
                    state_d = StSendHdr;
                end
            end
            StSendHdr: begin
                if (out_hs) begin
                    if (cnt_q == 3'd4) begin
                        tmo_d   = 16'd0;
                        state_d = we_q ? StSendWdata : StWaitStart;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StSendWdata: begin
                if (out_hs) state_d = StAck;
            end
            StWaitStart: begin
                if (in_hs) begin
                    tmo_d = 16'd0;
                    if (input_axis_tlast) begin
                        err_d   = 1'b1;
                        last_d  = 1'b1;
                        state_d = StSendTerm;
                    end else if (input_axis_tdata == FLAG_START) begin
                        state_d = StWaitData;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StSendTerm;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StWaitData: begin
                if (in_hs) begin
                    tmo_d   = 16'd0;
                    rdat_d  = input_axis_tdata;
                    state_d = StSendTerm;
                    if (input_axis_tlast) begin
                        err_d  = 1'b1;
                        last_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = StSendTerm;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StSendTerm: begin
                if (out_hs) state_d = last_q ? StAck : StDrain;
            end
            StDrain: begin
                if (in_hs && input_axis_tlast) state_d = StAck;
            end
            StAck: begin
                err_d   = 1'b0;
                last_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        case (state_d)
            StSendHdr:   tdata_d = hdr_byte(adr_d, we_d, cnt_d);
            StSendWdata: tdata_d = wdat_d;
            default:     tdata_d = BYTE_TERM;
        endcase
        tvalid_d  = (state_d == StSendHdr) || (state_d == StSendWdata) ||
                    (state_d == StSendTerm);
        tlast_d   = (state_d == StSendWdata) || (state_d == StSendTerm);
        itready_d = (state_d == StIdle) || (state_d == StWaitStart) ||
                    (state_d == StWaitData) || (state_d == StDrain);
        busy_d    = (state_d != StIdle);
        ack_d     = (state_d == StAck) && !err_d;
        werr_d    = (state_d == StAck) && err_d;
        dat_o_d   = ack_d ? rdat_d : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= StIdle;
            cnt_q              <= 3'd0;
            adr_q              <= 36'd0;
            wdat_q             <= 8'h00;
            rdat_q             <= 8'h00;
            we_q               <= 1'b0;
            err_q              <= 1'b0;
            last_q             <= 1'b0;
            tmo_q              <= 16'd0;
            output_axis_tdata  <= 8'h00;
            output_axis_tvalid <= 1'b0;
            output_axis_tlast  <= 1'b0;
            input_axis_tready  <= 1'b0;
            busy               <= 1'b0;
            wb_ack_o           <= 1'b0;
            wb_err_o           <= 1'b0;
            wb_dat_o           <= 8'h00;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            adr_q              <= adr_d;
            wdat_q             <= wdat_d;
            rdat_q             <= rdat_d;
            we_q               <= we_d;
            err_q              <= err_d;
            last_q             <= last_d;
            tmo_q              <= tmo_d;
            output_axis_tdata  <= tdata_d;
            output_axis_tvalid <= tvalid_d;
            output_axis_tlast  <= tlast_d;
            input_axis_tready  <= itready_d;
            busy               <= busy_d;
            wb_ack_o           <= ack_d;
            wb_err_o           <= werr_d;
            wb_dat_o           <= dat_o_d;
        end
    end

endmodule

// File: tb/tb_soc_master_wb_8.sv
// Directed self-checking bench for soc_master_wb_8 (TIMEOUT shortened to 20 cycles).
module tb_soc_master_wb_8;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] wb_adr_i;
    logic [7:0]  wb_dat_i;
    logic [7:0]  wb_dat_o;
    logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid, output_axis_tready, output_axis_tlast;
    logic [7:0]  input_axis_tdata;
    logic        input_axis_tvalid, input_axis_tready, input_axis_tlast;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    int stall_cnt = 0;
    logic [8:0] out_q[$];
    logic [8:0] exp_f[6];

    always #5 clk = ~clk;

    soc_master_wb_8 #(.TIMEOUT(16'd20)) dut (
        .clk                (clk),
        .rst                (rst),
        .wb_adr_i           (wb_adr_i),
        .wb_dat_i           (wb_dat_i),
        .wb_dat_o           (wb_dat_o),
        .wb_we_i            (wb_we_i),
        .wb_stb_i           (wb_stb_i),
        .wb_cyc_i           (wb_cyc_i),
        .wb_ack_o           (wb_ack_o),
        .wb_err_o           (wb_err_o),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .output_axis_tlast  (output_axis_tlast),
        .input_axis_tdata   (input_axis_tdata),
        .input_axis_tvalid  (input_axis_tvalid),
        .input_axis_tready  (input_axis_tready),
        .input_axis_tlast   (input_axis_tlast),
        .busy               (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Output-stream monitor, stall stability and pulse counting, sampled on the falling edge.
    initial begin
        logic       prev_stall;
        logic [8:0] prev_b;
        prev_stall = 1'b0;
        prev_b     = 9'h0;
        forever begin
            @(negedge clk);
            if (prev_stall && !rst) begin
                stall_cnt++;
                chk("stall_tvalid", 64'(output_axis_tvalid), 64'd1);
                chk("stall_tdata", 64'({output_axis_tlast, output_axis_tdata}), 64'(prev_b));
            end
            prev_stall = output_axis_tvalid && !output_axis_tready && !rst;
            prev_b     = {output_axis_tlast, output_axis_tdata};
            if (output_axis_tvalid && output_axis_tready)
                out_q.push_back({output_axis_tlast, output_axis_tdata});
            if (wb_ack_o) ack_cnt++;
            if (wb_err_o) err_cnt++;
        end
    end

    task automatic wb_start(input logic [35:0] a, input logic [7:0] d, input logic we);
        wb_adr_i = a;
        wb_dat_i = d;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(posedge clk); #1;
        // Dropping cyc after acceptance must not abort the frame.
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
    endtask

    task automatic send_in(input logic [7:0] b, input logic l);
        int n;
        n = 0;
        input_axis_tdata  = b;
        input_axis_tlast  = l;
        input_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!input_axis_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        input_axis_tvalid = 1'b0;
        input_axis_tlast  = 1'b0;
        chk($sformatf("in_hs_wait_%h", b), 64'(n < 200), 64'd1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!(wb_ack_o || wb_err_o) && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("wb_done_seen", 64'(wb_ack_o || wb_err_o), 64'd1);
    endtask

    task automatic chk_frame(input string tag);
        chk({tag, "_len"}, 64'(out_q.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < out_q.size())
                chk($sformatf("%s_b%0d", tag, i), 64'(out_q[i]), 64'(exp_f[i]));
            else
                chk($sformatf("%s_b%0d", tag, i), 64'hDEAD, 64'(exp_f[i]));
        end
    endtask

    initial begin
        int cyc;
        int n;
        logic [15:0] pat;

        rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        output_axis_tready = 1'b1;
        input_axis_tdata = '0; input_axis_tvalid = 1'b0; input_axis_tlast = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", 64'({wb_ack_o, wb_err_o, wb_dat_o, output_axis_tvalid,
            output_axis_tdata, output_axis_tlast, input_axis_tready, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_tready", 64'(input_axis_tready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);

        // Write, tready held high: 7 edges from stb assertion to visible ack
        out_q.delete();
        wb_start(36'h5_1234_5678, 8'hC3, 1'b1);
        wait_done(cyc);
        chk("wr_ack", 64'(wb_ack_o), 64'd1);
        chk("wr_latency", 64'(cyc + 1), 64'd7);
        @(posedge clk); #1;
        chk("wr_ack_single", 64'(wb_ack_o), 64'd0);
        exp_f = '{9'h0B5, 9'h012, 9'h034, 9'h056, 9'h078, 9'h1C3};
        chk_frame("wr");

        // Read: reply 01 9A 9B 00(last); 9B and 00 drained
        out_q.delete();
        wb_start(36'h0_0000_0010, 8'h00, 1'b0);
        send_in(8'h01, 1'b0);
        send_in(8'h9A, 1'b0);
        send_in(8'h9B, 1'b0);
        send_in(8'h00, 1'b1);
        wait_done(cyc);
        chk("rd_ack", 64'(wb_ack_o), 64'd1);
        chk("rd_err", 64'(wb_err_o), 64'd0);
        chk("rd_data", 64'(wb_dat_o), 64'h9A);
        exp_f = '{9'h0A0, 9'h000, 9'h000, 9'h000, 9'h010, 9'h100};
        chk_frame("rd");
        @(posedge clk); #1;

        // Backpressure: fixed pseudo-random tready pattern during a write
        out_q.delete();
        stall_cnt = 0;
        pat = 16'b1001_1100_0110_0101;
        wb_start(36'h5_1234_5678, 8'hC3, 1'b1);
        n = 0;
        while (!wb_ack_o && n < 200) begin
            output_axis_tready = pat[n % 16];
            @(posedge clk); #1;
            n++;
        end
        output_axis_tready = 1'b1;
        chk("bp_ack", 64'(wb_ack_o), 64'd1);
        chk("bp_stalls_seen", 64'(stall_cnt > 0), 64'd1);
        exp_f = '{9'h0B5, 9'h012, 9'h034, 9'h056, 9'h078, 9'h1C3};
        chk_frame("bp");
        @(posedge clk); #1;

        // Timeout: no reply; terminator exactly 20 edges after the last header handshake
        out_q.delete();
        wb_start(36'h0_0000_0020, 8'h00, 1'b0);
        n = 0;
        while (out_q.size() < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        n = 0;
        while (!output_axis_tvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_delay", 64'(n), 64'd20);
        chk("to_busy", 64'(busy), 64'd1);
        send_in(8'h77, 1'b1);
        wait_done(cyc);
        chk("to_err", 64'(wb_err_o), 64'd1);
        chk("to_ack", 64'(wb_ack_o), 64'd0);
        chk("to_data", 64'(wb_dat_o), 64'h00);
        exp_f = '{9'h0A0, 9'h000, 9'h000, 9'h000, 9'h020, 9'h100};
        chk_frame("to");
        @(posedge clk); #1;

        // Idle garbage discarded, then a read with a nonzero command nibble
        send_in(8'h55, 1'b0);
        send_in(8'hAA, 1'b0);
        chk("garbage_busy", 64'(busy), 64'd0);
        out_q.delete();
        wb_start(36'h3_0000_0030, 8'h00, 1'b0);
        send_in(8'h01, 1'b0);
        send_in(8'h5E, 1'b0);
        send_in(8'h00, 1'b1);
        wait_done(cyc);
        chk("gb_ack", 64'(wb_ack_o), 64'd1);
        chk("gb_data", 64'(wb_dat_o), 64'h5E);
        exp_f = '{9'h0A3, 9'h000, 9'h000, 9'h000, 9'h030, 9'h100};
        chk_frame("gb");
        @(posedge clk); #1;

        // Reset while waiting for read data, then a normal write
        wb_start(36'h0_0000_0040, 8'h00, 1'b0);
        send_in(8'h01, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", 64'({wb_ack_o, wb_err_o, wb_dat_o, output_axis_tvalid,
            output_axis_tdata, output_axis_tlast, input_axis_tready, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        out_q.delete();
        wb_start(36'hF_0000_0041, 8'h5A, 1'b1);
        wait_done(cyc);
        chk("rw_ack", 64'(wb_ack_o), 64'd1);
        exp_f = '{9'h0BF, 9'h000, 9'h000, 9'h000, 9'h041, 9'h15A};
        chk_frame("rw");
        @(posedge clk); #1;

        chk("total_acks", 64'(ack_cnt), 64'd5);
        chk("total_errs", 64'(err_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
